pulse_meter: RTL and testbench
==============================

// Module: pulse_meter
// PURPOSE
//  Measures high-pulse widths of a glitch-filtered, clock-synchronous level signal.
//  Sits directly downstream of the 4-sample glitch filter: its sig_out feeds sig_in here.
//  Each completed high pulse yields one width result on a valid/ready output port.
//  Also counts completed pulses and flags saturation and dropped results.
// PARAMETERS
//  CNT_W   16  width of width_out, period_out and pulse_count (>=2)
// PORTS
//  clock        in   1       system clock, rising edge
//  reset        in   1       asynchronous, active-low reset
//  sig_in       in   1       filtered level, already synchronous to clock
//  enable       in   1       1 = measure; 0 = abort current pulse and hold
//  clear_flags  in   1       synchronous clear of overrun and sat_flag
//  width_out    out  CNT_W   high width of last pulse, in clock samples
//  width_valid  out  1       width_out holds an unconsumed result
//  width_ready  in   1       consumer accepts when width_valid & width_ready at an edge
//  pulse_count  out  CNT_W   completed pulses since reset, wraps at 2^CNT_W
//  overrun      out  1       sticky: a result was dropped
//  sat_flag     out  1       sticky: a width counter saturated
// BEHAVIOUR
//  Reset (reset=0, async): FSM=WAIT_LOW; all outputs and counters 0.
//  FSM, evaluated on each rising clock edge with enable=1:
//   WAIT_LOW : sig_in=0 -> WAIT_RISE (no partial pulse measured after reset/enable).
//   WAIT_RISE: sig_in=1 -> HIGH, cnt<=1.
//   HIGH     : sig_in=1 -> cnt<=cnt+1, saturating at 2^CNT_W-1 (sets sat_flag);
//              sig_in=0 -> publish cnt, pulse_count+1, -> WAIT_RISE.
//  enable=0 at an edge: FSM->WAIT_LOW, cnt discarded; pending result, flags, pulse_count kept.
//  Width = number of clock edges sampling sig_in=1; width_valid rises at the same edge
//   that first samples sig_in=0 (visible in the following cycle).
//  Output handshake at each edge with a publish:
//   width_valid=0, or width_valid&width_ready -> load width_out, width_valid<=1.
//   width_valid=1 and width_ready=0 -> new result dropped, old held, overrun<=1.
//  No publish: width_valid&width_ready -> width_valid<=0; width_out holds last value.
//  width_out/width_valid stable while width_valid=1 and width_ready=0.
//  clear_flags clears overrun/sat_flag; set event in the same edge wins (flag stays 1).
//  pulse_count increments even when the result is dropped.
// CONFIGURATION
//  Macro PULSE_METER_PERIOD_EN:
//   defined: adds port period_out out CNT_W = edges from previous rising-edge sample to
//    this pulse's rising-edge sample, saturating (sets sat_flag); published with width_out
//    under the same valid/ready/overrun rules; 0 for the first pulse after reset/enable=0.
//   undefined: no period_out port, no period counter; all other behaviour identical.
// STRUCTURE
//  Package pulse_meter_pkg: FSM state localparams (WAIT_LOW, WAIT_RISE, HIGH, 2-bit encoding).
//  Sub-module sat_counter #(W): clear/load-1/increment, saturating, sat pulse output;
//   one instance for width, one for period when PULSE_METER_PERIOD_EN defined.
//  Top: FSM, result register + handshake, pulse_count, sticky flags.
// TESTING
//  Reset mid-pulse (sig_in=1, cnt=3): all outputs 0; sig_in held 1 -> no result until low seen.
//  enable=1, width_ready=1, sig_in high 5 edges -> width_out=5, width_valid 1 cycle, pulse_count=1.
//  CNT_W=4, sig_in high 20 edges -> width_out=15, sat_flag=1; clear_flags -> sat_flag=0.
//  width_ready=0, pulses of 3 then 7 -> width_out=3 held, overrun=1, pulse_count=2;
//   width_ready=1 -> valid drops next edge.
//  enable->0 after 4 high edges, then ->1, next 6-edge pulse -> width_out=6 (not 10).
//  PERIOD_EN: rising edges at edges 10, 30, 55 -> period_out 0, 20, 25.

Source files
------------

// File: rtl/pulse_meter_pkg.sv
// Shared FSM encoding for the pulse_meter block.
package pulse_meter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t WAIT_LOW  = 2'd0;
  localparam state_t WAIT_RISE = 2'd1;
  localparam state_t HIGH      = 2'd2;

endpackage

// File: rtl/pulse_meter_sat_counter.sv
// Saturating up-counter: clear, load-1 and increment with a one-cycle sat pulse
// whenever an increment is blocked at the maximum value.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    sat   = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (load1) begin
      cnt_d = ONE;
    end else if (inc) begin
      if (cnt_q == MAX) sat = 1'b1;
      else              cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pulse_meter.sv
// High-pulse width meter with valid/ready result port, pulse counter and sticky flags.
// Optional PULSE_METER_PERIOD_EN adds a rise-to-rise period result alongside the width.
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             enable,
  input  logic             clear_flags,
  output logic [CNT_W-1:0] width_out,
  output logic             width_valid,
  input  logic             width_ready,
`ifdef PULSE_METER_PERIOD_EN
  output logic [CNT_W-1:0] period_out,
`endif
  output logic [CNT_W-1:0] pulse_count,
  output logic             overrun,
  output logic             sat_flag
);

  state_t state_q, state_d;
  logic rise, extend, publish;
  logic [CNT_W-1:0] width_cnt;
  logic width_sat, period_sat;

  logic [CNT_W-1:0] width_out_q, width_out_d;
  logic             width_valid_q, width_valid_d;
  logic [CNT_W-1:0] pulse_count_q, pulse_count_d;
  logic             overrun_q, overrun_d;
  logic             sat_flag_q, sat_flag_d;
  logic             accept, overrun_set;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= WAIT_LOW;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = WAIT_LOW;
    end else begin
      case (state_q)
        WAIT_LOW:  if (!sig_in) state_d = WAIT_RISE;
        WAIT_RISE: if (sig_in)  state_d = HIGH;
        HIGH:      if (!sig_in) state_d = WAIT_RISE;
        default:   state_d = WAIT_LOW;
      endcase
    end
  end

  always_comb begin
    rise    = enable && (state_q == WAIT_RISE) && sig_in;
    extend  = enable && (state_q == HIGH) && sig_in;
    publish = enable && (state_q == HIGH) && !sig_in;
  end

  sat_counter #(.W(CNT_W)) u_width_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (!enable),
    .load1 (rise),
    .inc   (extend),
    .cnt   (width_cnt),
    .sat   (width_sat)
  );

`ifdef PULSE_METER_PERIOD_EN
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] period_pend_q, period_pend_d;
  logic [CNT_W-1:0] period_out_q, period_out_d;

  // A zero count means no rise seen since reset/disable, so the first period reads 0.
  sat_counter #(.W(CNT_W)) u_period_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (!enable),
    .load1 (rise),
    .inc   (enable && !rise && (period_cnt != '0)),
    .cnt   (period_cnt),
    .sat   (period_sat)
  );

  always_comb begin
    period_pend_d = rise ? period_cnt : period_pend_q;
    period_out_d  = (publish && accept) ? period_pend_q : period_out_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      period_pend_q <= '0;
      period_out_q  <= '0;
    end else begin
      period_pend_q <= period_pend_d;
      period_out_q  <= period_out_d;
    end
  end

  assign period_out = period_out_q;
`else
  assign period_sat = 1'b0;
`endif

  always_comb begin
    accept        = !width_valid_q || width_ready;
    width_out_d   = width_out_q;
    width_valid_d = width_valid_q;
    overrun_set   = 1'b0;
    if (publish) begin
      if (accept) begin
        width_out_d   = width_cnt;
        width_valid_d = 1'b1;
      end else begin
        overrun_set   = 1'b1;
      end
    end else if (width_valid_q && width_ready) begin
      width_valid_d = 1'b0;
    end
    pulse_count_d = pulse_count_q + {{(CNT_W-1){1'b0}}, publish};
    // Set beats clear when both land on the same edge.
    overrun_d  = overrun_set || (overrun_q && !clear_flags);
    sat_flag_d = width_sat || period_sat || (sat_flag_q && !clear_flags);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      width_out_q   <= '0;
      width_valid_q <= 1'b0;
      pulse_count_q <= '0;
      overrun_q     <= 1'b0;
      sat_flag_q    <= 1'b0;
    end else begin
      width_out_q   <= width_out_d;
      width_valid_q <= width_valid_d;
      pulse_count_q <= pulse_count_d;
      overrun_q     <= overrun_d;
      sat_flag_q    <= sat_flag_d;
    end
  end

  assign width_out   = width_out_q;
  assign width_valid = width_valid_q;
  assign pulse_count = pulse_count_q;
  assign overrun     = overrun_q;
  assign sat_flag    = sat_flag_q;

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter at CNT_W=4; period checks added when PULSE_METER_PERIOD_EN is defined.
module tb_pulse_meter;

  localparam int CNT_W = 4;

  logic             clock;
  logic             reset;
  logic             sig_in;
  logic             enable;
  logic             clear_flags;
  logic [CNT_W-1:0] width_out;
  logic             width_valid;
  logic             width_ready;
  logic [CNT_W-1:0] pulse_count;
  logic             overrun;
  logic             sat_flag;
`ifdef PULSE_METER_PERIOD_EN
  logic [CNT_W-1:0] period_out;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pulse_meter #(.CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .sig_in      (sig_in),
    .enable      (enable),
    .clear_flags (clear_flags),
    .width_out   (width_out),
    .width_valid (width_valid),
    .width_ready (width_ready),
`ifdef PULSE_METER_PERIOD_EN
    .period_out  (period_out),
`endif
    .pulse_count (pulse_count),
    .overrun     (overrun),
    .sat_flag    (sat_flag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // High for n edges, then one low edge that publishes the result.
  task automatic pulse(input int n);
    sig_in = 1'b1;
    repeat (n) tick();
    sig_in = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; enable = 1'b1; sig_in = 1'b0; width_ready = 1'b0; clear_flags = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    tick();

    // Build up state, then reset asynchronously mid-pulse
    pulse(2);
    check_eq("pre_valid", 32'(width_valid), 32'd1);
    check_eq("pre_width", 32'(width_out), 32'd2);
    pulse(2);
    check_eq("pre_overrun", 32'(overrun), 32'd1);
    check_eq("pre_count", 32'(pulse_count), 32'd2);
    sig_in = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check_eq("rst_valid", 32'(width_valid), 32'd0);
    check_eq("rst_width", 32'(width_out), 32'd0);
    check_eq("rst_count", 32'(pulse_count), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    check_eq("rst_sat", 32'(sat_flag), 32'd0);
`ifdef PULSE_METER_PERIOD_EN
    check_eq("rst_period", 32'(period_out), 32'd0);
`endif
    tick();
    reset = 1'b1;
    width_ready = 1'b1;
    repeat (5) tick();
    check_eq("rst_hold_high_valid", 32'(width_valid), 32'd0);
    sig_in = 1'b0;
    tick();
    check_eq("rst_low_valid", 32'(width_valid), 32'd0);
    check_eq("rst_low_count", 32'(pulse_count), 32'd0);

    // Basic 5-edge pulse
    pulse(5);
    check_eq("p5_width", 32'(width_out), 32'd5);
    check_eq("p5_valid", 32'(width_valid), 32'd1);
    check_eq("p5_count", 32'(pulse_count), 32'd1);
    tick();
    check_eq("p5_valid_drop", 32'(width_valid), 32'd0);
    check_eq("p5_width_hold", 32'(width_out), 32'd5);

    // Saturation at 15 and flag clear
    pulse(20);
    check_eq("sat_width", 32'(width_out), 32'd15);
    check_eq("sat_flag", 32'(sat_flag), 32'd1);
    check_eq("sat_count", 32'(pulse_count), 32'd2);
    tick();
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check_eq("sat_cleared", 32'(sat_flag), 32'd0);
    check_eq("sat_no_overrun", 32'(overrun), 32'd0);

    // Back-pressure: second result dropped
    width_ready = 1'b0;
    pulse(3);
    check_eq("bp_width3", 32'(width_out), 32'd3);
    check_eq("bp_valid3", 32'(width_valid), 32'd1);
    tick();
    pulse(7);
    check_eq("bp_width_held", 32'(width_out), 32'd3);
    check_eq("bp_valid_held", 32'(width_valid), 32'd1);
    check_eq("bp_overrun", 32'(overrun), 32'd1);
    check_eq("bp_count", 32'(pulse_count), 32'd4);
    width_ready = 1'b1;
    tick();
    check_eq("bp_valid_drop", 32'(width_valid), 32'd0);
    check_eq("bp_width_after", 32'(width_out), 32'd3);

    // Abort by enable=0 after 4 high edges
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check_eq("ovr_cleared", 32'(overrun), 32'd0);
    sig_in = 1'b1;
    repeat (4) tick();
    enable = 1'b0;
    sig_in = 1'b0;
    repeat (2) tick();
    check_eq("abort_valid", 32'(width_valid), 32'd0);
    check_eq("abort_count", 32'(pulse_count), 32'd4);
    enable = 1'b1;
    tick();
    pulse(6);
    check_eq("abort_width", 32'(width_out), 32'd6);
    check_eq("abort_count2", 32'(pulse_count), 32'd5);

    // Clear and overrun set on the same edge: set wins
    width_ready = 1'b0;
    tick();
    clear_flags = 1'b1;
    pulse(2);
    clear_flags = 1'b0;
    check_eq("clr_vs_set_overrun", 32'(overrun), 32'd1);
    check_eq("clr_vs_set_width", 32'(width_out), 32'd6);
    check_eq("clr_vs_set_count", 32'(pulse_count), 32'd6);
    width_ready = 1'b1;
    tick();
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;

    // pulse_count wraps at 16
    for (int i = 0; i < 10; i++) begin
      pulse(1);
      tick();
    end
    check_eq("wrap_count", 32'(pulse_count), 32'd0);
    check_eq("wrap_width", 32'(width_out), 32'd1);
    check_eq("wrap_valid", 32'(width_valid), 32'd0);

`ifdef PULSE_METER_PERIOD_EN
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    pulse(2);
    check_eq("per_first", 32'(period_out), 32'd0);
    repeat (4) tick();
    pulse(3);
    check_eq("per_7", 32'(period_out), 32'd7);
    tick();
    pulse(1);
    check_eq("per_5", 32'(period_out), 32'd5);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    repeat (20) tick();
    pulse(1);
    check_eq("per_sat", 32'(period_out), 32'd15);
    check_eq("per_sat_flag", 32'(sat_flag), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
